// File: rtl/mdio_link_poller.sv
// Clause-22 MDIO master: polls one PHY status register and decodes it into a 2-bit link code.
// Frame is 64 MDC bits plus one decode cycle; optional MDIO_LINK_POLLER_DEBOUNCE_EN filters link_st.
module mdio_link_poller #(
  parameter int         MDC_DIV        = 50,
  parameter int         POLL_CYCLES    = 10_000_000,
  parameter logic [4:0] PHY_ADDR       = 5'd0,
  parameter logic [4:0] SPEED_REG      = 5'd17,
  parameter int         LINK_BIT       = 10,
  parameter int         SPEED_MSB      = 15,
  parameter int         DEBOUNCE_COUNT = 3
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  output logic       mdc,
  output logic       mdio_o,
  output logic       mdio_oe,
  input  logic       mdio_i,
  output logic [1:0] link_st,
  output logic       link_valid,
  output logic       rd_error,
  output logic       busy
);

  localparam int DIV_W   = $clog2(2 * MDC_DIV);
  localparam int DIV_MAX = 2 * MDC_DIV - 1;
  localparam int POLL_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [13:0] CMD_WORD = {2'b01, 2'b10, PHY_ADDR, SPEED_REG};

  if (MDC_DIV < 2 || DEBOUNCE_COUNT < 1) begin : g_param_check
    $error("mdio_link_poller: MDC_DIV must be >= 2 and DEBOUNCE_COUNT >= 1");
  end

  typedef enum logic [2:0] {
    S_WAIT,
    S_PRE,
    S_CMD,
    S_TA,
    S_DATA,
    S_DECODE
  } state_t;

  state_t            state_q, state_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        bit_q, bit_d;
  logic [15:0]       shift_q, shift_d;
  logic              noresp_q, noresp_d;
  logic              mdc_q, mdc_d;
  logic              mdio_o_q, mdio_o_d;
  logic              mdio_oe_q, mdio_oe_d;
  logic [1:0]        link_st_q, link_st_d;
  logic              link_valid_q, link_valid_d;
  logic              rd_error_q, rd_error_d;

  logic              bit_end;
  logic              sample;
  logic              frame_d;
  logic [3:0]        cmd_idx;
  logic [1:0]        speed;
  logic              dec_err;
  logic [1:0]        cand;
  logic [1:0]        st_upd;

  assign bit_end = (div_q == DIV_W'(DIV_MAX));
  assign sample  = (div_q == DIV_W'(MDC_DIV));
  assign speed   = shift_q[SPEED_MSB -: 2];

  // Error frames decode to candidate 00 so the debounce filter treats them as link-down.
  always_comb begin
    dec_err = 1'b0;
    cand    = 2'b00;
    if (noresp_q) begin
      dec_err = 1'b1;
    end else if (shift_q[LINK_BIT]) begin
      case (speed)
        2'b10:   cand = 2'b10;
        2'b01:   cand = 2'b01;
        2'b00:   cand = 2'b11;
        default: dec_err = 1'b1;
      endcase
    end
  end

`ifdef MDIO_LINK_POLLER_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_COUNT + 1);

  logic [1:0]      db_cand_q, db_cand_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    db_cand_d = db_cand_q;
    db_cnt_d  = db_cnt_q;
    st_upd    = link_st_q;
    if (state_q == S_DECODE) begin
      if (cand == db_cand_q) begin
        if (db_cnt_q != DB_W'(DEBOUNCE_COUNT)) db_cnt_d = db_cnt_q + DB_W'(1);
      end else begin
        db_cand_d = cand;
        db_cnt_d  = DB_W'(1);
      end
      if (db_cnt_d == DB_W'(DEBOUNCE_COUNT)) st_upd = cand;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      db_cand_q <= 2'b00;
      db_cnt_q  <= '0;
    end else begin
      db_cand_q <= db_cand_d;
      db_cnt_q  <= db_cnt_d;
    end
  end
`else
  assign st_upd = cand;
`endif

  always_comb begin
    state_d      = state_q;
    poll_d       = poll_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    noresp_d     = noresp_q;
    link_st_d    = link_st_q;
    link_valid_d = link_valid_q;
    rd_error_d   = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (poll_q == POLL_W'(POLL_CYCLES - 1)) begin
          state_d  = S_PRE;
          poll_d   = '0;
          div_d    = '0;
          bit_d    = '0;
          noresp_d = 1'b0;
        end else begin
          poll_d = poll_q + POLL_W'(1);
        end
      end
      S_PRE, S_CMD, S_TA, S_DATA: begin
        if (state_q == S_TA && bit_q == 6'd47 && sample) noresp_d = mdio_i;
        if (state_q == S_DATA && sample) shift_d = {shift_q[14:0], mdio_i};
        if (bit_end) begin
          div_d = '0;
          bit_d = bit_q + 6'd1;
          case (bit_q)
            6'd31:   state_d = S_CMD;
            6'd45:   state_d = S_TA;
            6'd47:   state_d = S_DATA;
            6'd63:   state_d = S_DECODE;
            default: state_d = state_q;
          endcase
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DECODE: begin
        state_d      = S_WAIT;
        poll_d       = '0;
        link_valid_d = ~dec_err;
        rd_error_d   = dec_err;
        link_st_d    = st_upd;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Pin drivers are computed from next state so they register in step with the bit counters.
  assign frame_d = (state_d == S_PRE) || (state_d == S_CMD) ||
                   (state_d == S_TA)  || (state_d == S_DATA);
  assign cmd_idx = 4'(6'd45 - bit_d);

  always_comb begin
    mdc_d     = frame_d && (div_d >= DIV_W'(MDC_DIV));
    mdio_o_d  = mdio_o_q;
    mdio_oe_d = mdio_oe_q;
    if (!frame_d) begin
      mdio_o_d  = 1'b1;
      mdio_oe_d = 1'b0;
    end else if (div_d == '0) begin
      if (bit_d < 6'd32) begin
        mdio_o_d  = 1'b1;
        mdio_oe_d = 1'b1;
      end else if (bit_d < 6'd46) begin
        mdio_o_d  = CMD_WORD[cmd_idx];
        mdio_oe_d = 1'b1;
      end else begin
        mdio_o_d  = 1'b1;
        mdio_oe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q      <= S_WAIT;
      poll_q       <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      noresp_q     <= 1'b0;
      mdc_q        <= 1'b0;
      mdio_o_q     <= 1'b1;
      mdio_oe_q    <= 1'b0;
      link_st_q    <= 2'b00;
      link_valid_q <= 1'b0;
      rd_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      poll_q       <= poll_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      noresp_q     <= noresp_d;
      mdc_q        <= mdc_d;
      mdio_o_q     <= mdio_o_d;
      mdio_oe_q    <= mdio_oe_d;
      link_st_q    <= link_st_d;
      link_valid_q <= link_valid_d;
      rd_error_q   <= rd_error_d;
    end
  end

  assign mdc        = mdc_q;
  assign mdio_o     = mdio_o_q;
  assign mdio_oe    = mdio_oe_q;
  assign link_st    = link_st_q;
  assign link_valid = link_valid_q;
  assign rd_error   = rd_error_q;
  assign busy       = (state_q != S_WAIT);

endmodule

// File: tb/tb_mdio_link_poller.sv
// Scoreboard bench for mdio_link_poller: PHY model on mdio_i, expected decodes queued per frame.
// A monitor checks frame format, busy width, poll gap and decoded outputs at each frame end.
module tb_mdio_link_poller;

  localparam int MDC_DIV     = 2;
  localparam int POLL_CYCLES = 100;
  localparam int BUSY_LEN    = 128 * MDC_DIV + 1;

  typedef struct {
    logic [1:0] st;
    logic       valid;
    logic       err;
    logic       abort;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       mdc, mdio_o, mdio_oe;
  logic       mdio_i = 1'b1;
  logic [1:0] link_st;
  logic       link_valid, rd_error, busy;

  logic [15:0] phy_word = 16'h0000;
  logic        no_phy = 1'b0;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  mdio_link_poller #(
    .MDC_DIV(MDC_DIV), .POLL_CYCLES(POLL_CYCLES), .PHY_ADDR(5'd1),
    .SPEED_REG(5'd17), .LINK_BIT(10), .SPEED_MSB(15), .DEBOUNCE_COUNT(3)
  ) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .mdio_i(mdio_i), .link_st(link_st), .link_valid(link_valid),
    .rd_error(rd_error), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic phy_bit(input int n);
    if (no_phy) return 1'b1;
    if (n == 47) return 1'b0;
    if (n >= 48 && n <= 63) return phy_word[63 - n];
    return 1'b1;
  endfunction

  // PHY model: presents the next bit just after each MDC falling edge.
  initial begin : phy
    logic pm;
    int   rises;
    pm = 1'b0;
    rises = 0;
    forever begin
      @(negedge sys_clk);
      if (!busy) begin
        rises = 0;
        mdio_i = 1'b1;
      end else begin
        if (mdc && !pm) rises++;
        if (!mdc && pm) mdio_i = phy_bit(rises);
      end
      pm = mdc;
    end
  end

  initial begin : monitor
    exp_t        e;
    logic        pb, pm, chk_pulse, pre_ok, oe_ok;
    logic [13:0] cmd_sh;
    int          width, rk, gap;
    pb = 1'b0; pm = 1'b0; chk_pulse = 1'b0; pre_ok = 1'b1; oe_ok = 1'b1;
    cmd_sh = '0; width = 0; rk = 0; gap = 0;
    forever begin
      @(negedge sys_clk);
      if (chk_pulse) begin
        check("rd_error_width", rd_error, 1'b0);
        chk_pulse = 1'b0;
      end
      if (sys_reset) gap = 0;
      else if (!busy) gap++;
      if (busy && !pb) begin
        check("poll_gap", gap, POLL_CYCLES);
        gap = 0; width = 0; rk = 0; pre_ok = 1'b1; oe_ok = 1'b1; cmd_sh = '0;
      end
      if (busy) width++;
      if (busy && mdc && !pm) begin
        if (rk < 32) begin
          if (!(mdio_o === 1'b1 && mdio_oe === 1'b1)) pre_ok = 1'b0;
        end else if (rk < 46) begin
          if (mdio_oe !== 1'b1) pre_ok = 1'b0;
          cmd_sh = {cmd_sh[12:0], mdio_o};
        end else if (mdio_oe !== 1'b0) begin
          oe_ok = 1'b0;
        end
        rk++;
      end
      if (!busy && pb) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: frame ended with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          check("link_st", link_st, e.st);
          check("link_valid", link_valid, e.valid);
          check("rd_error", rd_error, e.err);
          if (e.abort) begin
            check("abort_mdc", mdc, 1'b0);
            check("abort_mdio_oe", mdio_oe, 1'b0);
          end else begin
            check("busy_width", width, BUSY_LEN);
            check("mdc_bits", rk, 64);
            check("cmd_bits", cmd_sh, 14'b01_10_00001_10001);
            check("pre_cmd_drive", pre_ok, 1'b1);
            check("ta_data_release", oe_ok, 1'b1);
            chk_pulse = 1'b1;
          end
        end
      end
      pb = busy;
      pm = mdc;
    end
  end

  task automatic wait_busy(input logic lvl, input int limit, input string what);
    int n;
    n = 0;
    while (busy !== lvl && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (busy !== lvl) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, expected %b", what, busy, n, lvl);
    end
  endtask

  task automatic run_frame(input logic [15:0] w, input logic np, input logic [1:0] st,
                           input logic v, input logic er);
    exp_t e;
    phy_word = w;
    no_phy = np;
    e.st = st; e.valid = v; e.err = er; e.abort = 1'b0;
    exp_q.push_back(e);
    wait_busy(1'b1, POLL_CYCLES + 20, "frame_start");
    wait_busy(1'b0, BUSY_LEN + 20, "frame_end");
  endtask

  initial begin : stimulus
    exp_t e;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_mdc", mdc, 1'b0);
    check("rst_mdio_o", mdio_o, 1'b1);
    check("rst_mdio_oe", mdio_oe, 1'b0);
    check("rst_link_st", link_st, 2'b00);
    check("rst_link_valid", link_valid, 1'b0);
    check("rst_rd_error", rd_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge sys_clk);
    #1 sys_reset = 1'b0;

`ifdef MDIO_LINK_POLLER_DEBOUNCE_EN
    run_frame(16'hAC00, 1'b0, 2'b00, 1'b1, 1'b0);
    run_frame(16'hAC00, 1'b0, 2'b00, 1'b1, 1'b0);
    run_frame(16'h6400, 1'b0, 2'b00, 1'b1, 1'b0);
    run_frame(16'hAC00, 1'b0, 2'b00, 1'b1, 1'b0);
    run_frame(16'hAC00, 1'b0, 2'b00, 1'b1, 1'b0);
    run_frame(16'hAC00, 1'b0, 2'b10, 1'b1, 1'b0);
`else
    run_frame(16'hAC00, 1'b0, 2'b10, 1'b1, 1'b0);
    run_frame(16'h6400, 1'b0, 2'b01, 1'b1, 1'b0);
    run_frame(16'h0400, 1'b0, 2'b11, 1'b1, 1'b0);
    run_frame(16'h8000, 1'b0, 2'b00, 1'b1, 1'b0);
    run_frame(16'hFFFF, 1'b1, 2'b00, 1'b0, 1'b1);
    run_frame(16'hC400, 1'b0, 2'b00, 1'b0, 1'b1);
    run_frame(16'hAC00, 1'b0, 2'b10, 1'b1, 1'b0);

    // Abort during DATA bit 5 (frame bit 53); outputs must show reset values.
    phy_word = 16'hAC00;
    no_phy = 1'b0;
    e.st = 2'b00; e.valid = 1'b0; e.err = 1'b0; e.abort = 1'b1;
    exp_q.push_back(e);
    wait_busy(1'b1, POLL_CYCLES + 20, "abort_frame_start");
    repeat (53 * 2 * MDC_DIV + 1) @(posedge sys_clk);
    #1 sys_reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_reset = 1'b0;
    run_frame(16'hAC00, 1'b0, 2'b10, 1'b1, 1'b0);
`endif

    repeat (5) @(negedge sys_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
